// File: rtl/inst_sequencer.sv
// Instruction fetch/sequencing stage: fetches words from a synchronous instruction memory,
// strips NOP/REPEAT/HALT, expands non-nesting REPEAT loops and hands the rest to the decoder.
module inst_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic                  imem_rd_en,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic [INST_WIDTH-1:0] inst,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [15:0]           issued_count
);

  localparam int unsigned OP_WIDTH  = 4;
  localparam int unsigned REP_WIDTH = 12;
  localparam int unsigned LEN_WIDTH = 8;
  localparam int unsigned CNT_WIDTH = 16;

  localparam logic [OP_WIDTH-1:0] OP_NOP    = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_HALT   = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_REPEAT = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE
  } state_t;

  state_t                  state, state_d;
  logic [ADDR_WIDTH-1:0]   pc, pc_d;
  logic [ADDR_WIDTH-1:0]   loop_start, loop_start_d;
  logic [ADDR_WIDTH-1:0]   loop_end, loop_end_d;
  logic [REP_WIDTH-1:0]    remaining, remaining_d;
  logic                    loop_active, loop_active_d;
  logic [CNT_WIDTH-1:0]    count_d;
  logic [INST_WIDTH-1:0]   inst_d;
  logic                    done_d;

  logic [ADDR_WIDTH-1:0]   adv_pc;
  logic [REP_WIDTH-1:0]    adv_remaining;
  logic                    adv_active;

  logic [OP_WIDTH-1:0]     opcode;
  logic [REP_WIDTH-1:0]    rep_n;
  logic [LEN_WIDTH-1:0]    rep_l;

  assign opcode    = imem_rdata[INST_WIDTH-1 -: OP_WIDTH];
  assign rep_n     = imem_rdata[27:16];
  assign rep_l     = imem_rdata[15:8];
  assign imem_addr = pc;

  // Sequential PC update: jump back at the body end while iterations remain.
  always_comb begin
    adv_pc        = pc + ADDR_WIDTH'(1);
    adv_remaining = remaining;
    adv_active    = loop_active;
    if (loop_active && (pc == loop_end)) begin
      if (remaining != '0) begin
        adv_pc        = loop_start;
        adv_remaining = remaining - REP_WIDTH'(1);
      end else begin
        adv_active = 1'b0;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    loop_start_d  = loop_start;
    loop_end_d    = loop_end;
    remaining_d   = remaining;
    loop_active_d = loop_active;
    count_d       = issued_count;
    inst_d        = inst;
    done_d        = 1'b0;

    case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped.
        if (start && !done) begin
          pc_d          = start_addr;
          count_d       = '0;
          loop_active_d = 1'b0;
          remaining_d   = '0;
          state_d       = S_FETCH;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        inst_d = imem_rdata;
        case (opcode)
          OP_HALT: begin
            done_d        = 1'b1;
            loop_active_d = 1'b0;
            state_d       = S_IDLE;
          end
          OP_NOP: begin
            pc_d          = adv_pc;
            remaining_d   = adv_remaining;
            loop_active_d = adv_active;
            state_d       = S_FETCH;
          end
          OP_REPEAT: begin
            if ((rep_n == '0) || (rep_l == '0) || loop_active) begin
              pc_d          = adv_pc;
              remaining_d   = adv_remaining;
              loop_active_d = adv_active;
            end else begin
              loop_start_d  = pc + ADDR_WIDTH'(1);
              loop_end_d    = pc + ADDR_WIDTH'(rep_l);
              remaining_d   = rep_n - REP_WIDTH'(1);
              loop_active_d = 1'b1;
              pc_d          = pc + ADDR_WIDTH'(1);
            end
            state_d = S_FETCH;
          end
          default: begin
            state_d = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (inst_ready) begin
          count_d       = issued_count + CNT_WIDTH'(1);
          pc_d          = adv_pc;
          remaining_d   = adv_remaining;
          loop_active_d = adv_active;
          state_d       = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Datapath and registered outputs, decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc           <= '0;
      loop_start   <= '0;
      loop_end     <= '0;
      remaining    <= '0;
      loop_active  <= 1'b0;
      issued_count <= '0;
      inst         <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      imem_rd_en   <= 1'b0;
      inst_valid   <= 1'b0;
    end else begin
      pc           <= pc_d;
      loop_start   <= loop_start_d;
      loop_end     <= loop_end_d;
      remaining    <= remaining_d;
      loop_active  <= loop_active_d;
      issued_count <= count_d;
      inst         <= inst_d;
      done         <= done_d;
      busy         <= (state_d != S_IDLE);
      imem_rd_en   <= (state_d == S_FETCH);
      inst_valid   <= (state_d == S_ISSUE);
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Scoreboard bench for inst_sequencer with a 16-word instruction memory (ADDR_WIDTH=4)
// so PC and loop-end wrap can be exercised.
module tb_inst_sequencer;

  localparam int unsigned AW = 4;
  localparam int unsigned IW = 32;

  localparam logic [31:0] W_HALT = 32'h9000_0000;
  localparam logic [31:0] W_NOP  = 32'h0000_0000;
  localparam logic [31:0] W_MAT  = 32'h1234_5678;
  localparam logic [31:0] W_ACC  = 32'h2ABC_DEF0;
  localparam logic [31:0] W_A    = 32'h1000_0A0A;
  localparam logic [31:0] W_B    = 32'h2000_0B0B;
  localparam logic [31:0] W_C    = 32'h3000_0C0C;
  localparam logic [31:0] W_D    = 32'hB000_00DD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic          busy, done, imem_rd_en, inst_valid;
  logic          inst_ready = 1'b1;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic [IW-1:0] inst;
  logic [15:0]   issued_count;

  logic [31:0] mem [16];
  logic [31:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          done_cnt = 0;
  logic        stall_pending = 1'b0;
  logic [31:0] stall_inst = '0;

  inst_sequencer #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .busy         (busy),
    .done         (done),
    .imem_addr    (imem_addr),
    .imem_rd_en   (imem_rd_en),
    .imem_rdata   (imem_rdata),
    .inst         (inst),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rep(input int n, input int l);
    logic [11:0] nn;
    logic [7:0]  ll;
    nn = n[11:0];
    ll = l[7:0];
    return {4'hA, nn, ll, 8'h00};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = W_HALT;
  endtask

  task automatic do_start(input logic [AW-1:0] a);
    @(posedge clk); #1;
    start_addr = a;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Wait for done, try a start in the done cycle (must be ignored), then check totals.
  task automatic finish_test(input string name, input int exp_count);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check({name, "_done_seen"}, 32'(found), 32'd1);
    if (!found) begin
      apply_reset();
      exp_q.delete();
    end else begin
      start = 1'b1;
      start_addr = '0;
      @(negedge clk);
      check({name, "_busy_low"}, 32'(busy), 32'd0);
      check({name, "_start_in_done_ignored"}, 32'(imem_rd_en), 32'd0);
      start = 1'b0;
    end
    check({name, "_issued_count"}, 32'(issued_count), 32'(exp_count));
    check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    exp_q.delete();
    done_cnt = 0;
  endtask

  // Monitor: pops the scoreboard on each handshake and watches stalled outputs.
  initial begin
    logic [31:0] exp_word;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_pending = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (inst_valid) begin
          if (stall_pending) check("stall_inst_stable", inst, stall_inst);
          if (inst_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_issue: got %h expected none at %0t", inst, $time);
            end else begin
              exp_word = exp_q.pop_front();
              check("issue_order", inst, exp_word);
            end
            stall_pending = 1'b0;
          end else begin
            stall_pending = 1'b1;
            stall_inst = inst;
          end
        end else if (stall_pending) begin
          check("valid_held_until_handshake", 32'(inst_valid), 32'd1);
          stall_pending = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_count", 32'(issued_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Linear program with first-issue latency.
    clear_mem();
    mem[4] = W_MAT; mem[5] = W_ACC; mem[6] = W_HALT;
    exp_q.push_back(W_MAT); exp_q.push_back(W_ACC);
    do_start(4'd4);
    @(negedge clk);
    check("lin_c1_busy", 32'(busy), 32'd1);
    check("lin_c1_rd_en", 32'(imem_rd_en), 32'd1);
    check("lin_c1_addr", 32'(imem_addr), 32'd4);
    check("lin_c1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("lin_c2_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    check("lin_c3_valid", 32'(inst_valid), 32'd1);
    finish_test("linear", 2);

    // Loop N=3, L=2.
    clear_mem();
    mem[0] = rep(3, 2); mem[1] = W_A; mem[2] = W_B; mem[3] = W_C; mem[4] = W_HALT;
    for (int i = 0; i < 3; i++) begin exp_q.push_back(W_A); exp_q.push_back(W_B); end
    exp_q.push_back(W_C);
    do_start(4'd0);
    finish_test("loop", 7);

    // Degenerate REPEATs plus an undefined opcode that must issue.
    clear_mem();
    mem[0] = rep(0, 2); mem[1] = W_A; mem[2] = rep(3, 0); mem[3] = W_D; mem[4] = W_NOP;
    mem[5] = W_HALT;
    exp_q.push_back(W_A); exp_q.push_back(W_D);
    do_start(4'd0);
    finish_test("degenerate", 2);

    // REPEAT inside an active body is ignored.
    clear_mem();
    mem[0] = rep(2, 3); mem[1] = W_A; mem[2] = rep(5, 1); mem[3] = W_B; mem[4] = W_HALT;
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_A); exp_q.push_back(W_B);
    do_start(4'd0);
    finish_test("nested", 4);

    // Backpressure on the second instruction for 5 cycles.
    clear_mem();
    mem[0] = W_A; mem[1] = W_B; mem[2] = W_C; mem[3] = W_HALT;
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_C);
    do_start(4'd0);
    repeat (5) @(posedge clk);
    #1 inst_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_valid_held", 32'(inst_valid), 32'd1);
    check("bp_inst_held", inst, W_B);
    check("bp_count_held", 32'(issued_count), 32'd1);
    inst_ready = 1'b1;
    finish_test("backpressure", 3);

    // PC and loop end wrap past address 15.
    clear_mem();
    mem[14] = rep(2, 2); mem[15] = W_A; mem[0] = W_B; mem[1] = W_C; mem[2] = W_HALT;
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_A); exp_q.push_back(W_B);
    exp_q.push_back(W_C);
    do_start(4'd14);
    finish_test("wrap", 5);

    // HALT inside a loop body, then a fresh start must see no stale loop.
    clear_mem();
    mem[0] = rep(5, 2); mem[1] = W_A; mem[2] = W_HALT; mem[3] = W_C; mem[4] = W_HALT;
    exp_q.push_back(W_A);
    do_start(4'd0);
    finish_test("halt_in_loop", 1);
    mem[2] = W_B; mem[3] = W_HALT;
    exp_q.push_back(W_A); exp_q.push_back(W_B);
    do_start(4'd1);
    finish_test("after_halt_loop", 2);

    // Reset while an instruction is pending.
    clear_mem();
    mem[0] = W_A; mem[1] = W_B; mem[2] = W_HALT;
    inst_ready = 1'b0;
    do_start(4'd0);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    check("pre_rst_inst", inst, W_A);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_inst", inst, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("mid_rst_addr", 32'(imem_addr), 32'd0);
    check("mid_rst_count", 32'(issued_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_no_done", 32'(done_cnt), 32'd0);
    inst_ready = 1'b1;
    exp_q.push_back(W_A); exp_q.push_back(W_B);
    do_start(4'd0);
    finish_test("after_reset", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_sequencer.md
# inst_sequencer

Instruction fetch and sequencing stage placed directly upstream of the instruction decoder. It reads 32-bit instruction words from a synchronous instruction memory and removes `INST_NOP`, `INST_REPEAT` and `INST_HALT` from the stream. It expands `INST_REPEAT` loops and hands every other instruction to the decoder through a valid/ready handshake.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: instruction memory address width; PC width.
- `INST_WIDTH`, default 32: instruction word width. Mnemonic is in bits [31:28].

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to begin execution at `start_addr`. Ignored while `busy`.
- `start_addr`  in  ADDR_WIDTH  first instruction address.
- `busy`  out  1  high from the cycle after `start` is accepted until the HALT is consumed.
- `done`  out  1  one-cycle pulse when an `INST_HALT` is consumed.
- `imem_addr`  out  ADDR_WIDTH  instruction memory read address (equals PC).
- `imem_rd_en`  out  1  read strobe.
- `imem_rdata`  in  INST_WIDTH  read data, valid exactly 1 cycle after `imem_rd_en`.
- `inst`  out  INST_WIDTH  instruction to the decoder.
- `inst_valid`  out  1  `inst` is valid.
- `inst_ready`  in  1  decoder accepts `inst`.
- `issued_count`  out  16  number of instructions handed off since the last accepted `start`. Wraps at 2^16.

## Operation
- FSM states: IDLE, FETCH, DECODE, ISSUE.
- IDLE: `start`=1 loads PC←`start_addr`, clears `issued_count` and loop state, then goes to FETCH.
- FETCH: `imem_rd_en`=1 and `imem_addr`=PC. Always goes to DECODE.
- DECODE: latches `imem_rdata` into the instruction register, then dispatches on mnemonic:
  - `INST_HALT` (9): pulse `done`, clear loop state, go to IDLE. This applies even inside a loop body.
  - `INST_NOP` (0): ADVANCE, then FETCH. Nothing is issued.
  - `INST_REPEAT` (10): fields are N=[27:16] (12-bit total iteration count) and L=[15:8] (8-bit body length, in instructions following the REPEAT).
    - If N=0 or L=0, it is treated as NOP.
    - If a loop is already active, it is treated as NOP; loops do not nest.
    - Otherwise set loop_start=PC+1, loop_end=PC+L (modulo 2^ADDR_WIDTH), remaining=N-1 and loop_active=1. Then PC←PC+1 (no ADVANCE check) and go to FETCH.
  - Any other code, including undefined codes 11–15: go to ISSUE.
- ISSUE: `inst_valid`=1 and `inst` holds the latched word.
  - On `inst_valid && inst_ready`: increment `issued_count`, ADVANCE, go to FETCH.
  - Otherwise hold. `inst` must stay stable while stalled.
- ADVANCE (PC update rule):
  - If loop_active and PC==loop_end and remaining>0: PC←loop_start, remaining←remaining-1.
  - If loop_active and PC==loop_end and remaining==0: loop_active←0, PC←PC+1.
  - Otherwise PC←PC+1.
- NOPs inside a body count toward L and obey ADVANCE.
- PC wraps from 2^ADDR_WIDTH-1 to 0.

## Timing
- Reset values: `busy`=0, `done`=0, `imem_rd_en`=0, `imem_addr`=0, `inst`=0, `inst_valid`=0, `issued_count`=0. State is IDLE, loop_active=0.
- `start` sampled at edge E0. FETCH is the cycle after E0, DECODE follows, and `inst_valid` rises in the third cycle after E0.
- Steady throughput with `inst_ready` held high is one issued instruction per 3 cycles. Each NOP or REPEAT costs 2 cycles.
- `done` is asserted in the cycle after the HALT's DECODE. `busy` falls in that same cycle.
- `start` asserted in the same cycle as `done` is ignored. `start` is accepted only in IDLE.
- `rst` asserted mid-operation immediately returns all outputs to reset values, including dropping a pending `inst_valid`. No `done` is produced.
- `inst_valid` never deasserts without a handshake, except on reset.

## Test plan
- Linear program: start_addr=4, memory [4]=MATMUL, [5]=ACCMOV, [6]=HALT, `inst_ready`=1.
  - Expect 2 issues in order, the first with `inst_valid` high in the third cycle after start.
  - `done` pulses once, `issued_count`=2, `busy` then low.
- Loop: start_addr=0, [0]=REPEAT N=3,L=2, [1]=A, [2]=B, [3]=C, [4]=HALT.
  - Expect issue order A,B,A,B,A,B,C, then `issued_count`=7.
- Degenerate and forbidden REPEATs:
  - REPEAT N=0 and REPEAT L=0 each issue nothing and execution continues.
  - A REPEAT inside an active body is ignored; the outer loop count is unchanged.
- Backpressure: hold `inst_ready`=0 for 5 cycles mid-program.
  - `inst_valid` and `inst` remain stable, with no duplicate or skipped issue.
- Wrap and HALT-in-loop:
  - ADDR_WIDTH=4 with program at 15 wrapping to 0: issue order preserved.
  - HALT at the body's second slot with N=5: `done` after the first pass, and a new start runs with loop_active=0.
- Reset during ISSUE with `inst_valid`=1: all outputs at reset values the same cycle, and the next `start` runs normally.
